// File: rtl/seven_segment_decoder_pkg.sv
// Shared segment masks, glyph codes and decoder FSM encodings.
// Patterns are lit-high, bit6..bit0 = G..A.
package seven_segment_decoder_pkg;

  localparam logic [6:0] SEGMENT_A = 7'h01;
  localparam logic [6:0] SEGMENT_B = 7'h02;
  localparam logic [6:0] SEGMENT_C = 7'h04;
  localparam logic [6:0] SEGMENT_D = 7'h08;
  localparam logic [6:0] SEGMENT_E = 7'h10;
  localparam logic [6:0] SEGMENT_F = 7'h20;
  localparam logic [6:0] SEGMENT_G = 7'h40;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [1:0] S_WAIT     = 2'd0;
  localparam logic [1:0] S_SETTLING = 2'd1;
  localparam logic [1:0] S_STABLE   = 2'd2;

  function automatic logic [6:0] normalize(
    input logic [6:0] raw,
    input logic       active_low
  );
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/seven_segment_decoder_glyph.sv
// Combinational glyph lookup: lit-high pattern to legal flag
// and hex nibble.
module seven_segment_decoder_glyph
  import seven_segment_decoder_pkg::*;
(
  input  logic [6:0] i_Pattern,
  output logic       o_Legal,
  output logic [3:0] o_Nibble
);

  always_comb begin
    o_Legal  = 1'b1;
    o_Nibble = 4'h0;
    unique case (i_Pattern)
      GLYPH_0: o_Nibble = 4'h0;
      GLYPH_1: o_Nibble = 4'h1;
      GLYPH_2: o_Nibble = 4'h2;
      GLYPH_3: o_Nibble = 4'h3;
      GLYPH_4: o_Nibble = 4'h4;
      GLYPH_5: o_Nibble = 4'h5;
      GLYPH_6: o_Nibble = 4'h6;
      GLYPH_7: o_Nibble = 4'h7;
      GLYPH_8: o_Nibble = 4'h8;
      GLYPH_9: o_Nibble = 4'h9;
      GLYPH_A: o_Nibble = 4'hA;
      GLYPH_B: o_Nibble = 4'hB;
      GLYPH_C: o_Nibble = 4'hC;
      GLYPH_D: o_Nibble = 4'hD;
      GLYPH_E: o_Nibble = 4'hE;
      GLYPH_F: o_Nibble = 4'hF;
      default: o_Legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Debounced seven-segment pin decoder: synchronizes raw pins,
// waits for a stable pattern, then commits glyph/blank/error.
module seven_segment_decoder
  import seven_segment_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Reset_L,
  input  logic [6:0] i_Segments,
  output logic [3:0] o_Nibble,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Error,
  output logic       o_Update,
  output logic [7:0] o_Change_Count
);

  localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

  logic [6:0] r_sync1;
  logic [6:0] r_sync2;
  logic [2:0] r_fill;
  logic [6:0] r_prev_p;
  logic [7:0] r_cnt;
  logic [6:0] r_comm;
  logic [1:0] r_state;

  logic [6:0] w_p;
  logic       w_same;
  logic [7:0] w_cnt_nxt;
  logic       w_commit;
  logic       w_legal;
  logic [3:0] w_nibble;
  logic [1:0] w_state_nxt;

  assign w_p = normalize(r_sync2, ACTIVE_LOW);

  // r_fill marks when r_sync2 and r_prev_p hold real pin samples
  assign w_same = r_fill[2] && (w_p == r_prev_p);

  assign w_cnt_nxt = !w_same                ? 8'd1 :
                     (r_cnt == LP_STABLE)   ? r_cnt :
                                              r_cnt + 8'd1;

  assign w_commit = r_fill[1] &&
                    (w_cnt_nxt == LP_STABLE) &&
                    ((w_p != r_comm) || (r_state == S_WAIT));

  seven_segment_decoder_glyph u_glyph (
    .i_Pattern (w_p),
    .o_Legal   (w_legal),
    .o_Nibble  (w_nibble)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_WAIT:
        if (w_commit) w_state_nxt = S_STABLE;
      S_STABLE:
        if (w_commit)             w_state_nxt = S_STABLE;
        else if (w_p != r_comm)   w_state_nxt = S_SETTLING;
      S_SETTLING:
        if (w_commit || (w_p == r_comm))
          w_state_nxt = S_STABLE;
      default:
        w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_L) begin
      r_sync1        <= '0;
      r_sync2        <= '0;
      r_fill         <= '0;
      r_prev_p       <= '0;
      r_cnt          <= '0;
      r_comm         <= '0;
      r_state        <= S_WAIT;
      o_Nibble       <= '0;
      o_Valid        <= 1'b0;
      o_Blank        <= 1'b0;
      o_Error        <= 1'b0;
      o_Update       <= 1'b0;
      o_Change_Count <= '0;
    end else begin
      r_sync1  <= i_Segments;
      r_sync2  <= r_sync1;
      r_fill   <= {r_fill[1:0], 1'b1};
      r_prev_p <= w_p;
      r_cnt    <= w_cnt_nxt;
      r_state  <= w_state_nxt;
      o_Update <= w_commit;
      if (w_commit) begin
        r_comm         <= w_p;
        o_Valid        <= w_legal;
        o_Blank        <= (w_p == 7'h00);
        o_Error        <= !w_legal && (w_p != 7'h00);
        o_Change_Count <= o_Change_Count + 8'd1;
        if (w_legal) o_Nibble <= w_nibble;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Randomized bench for seven_segment_decoder against a
// sample-window reference model.
module tb_seven_segment_decoder;

  localparam int S  = 4;
  localparam bit AL = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [3:0] o_Nibble;
  logic       o_Valid;
  logic       o_Blank;
  logic       o_Error;
  logic       o_Update;
  logic [7:0] o_Change_Count;

  seven_segment_decoder #(
    .STABLE_CYCLES (S),
    .ACTIVE_LOW    (AL)
  ) dut (
    .i_Clk          (clk),
    .i_Reset_L      (rst_n),
    .i_Segments     (seg),
    .o_Nibble       (o_Nibble),
    .o_Valid        (o_Valid),
    .o_Blank        (o_Blank),
    .o_Error        (o_Error),
    .o_Update       (o_Update),
    .o_Change_Count (o_Change_Count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [6:0] GL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (GL[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [6:0] norm(input logic [6:0] x);
    return AL ? ~x : x;
  endfunction

  // Model: pins seen at each post-reset edge; a commit happens
  // once the last S synchronized samples agree and differ from
  // the committed pattern.
  int         hist[$];
  logic [6:0] m_comm;
  bit         m_any;
  logic [3:0] m_nib;
  bit         m_v, m_b, m_e, m_u;
  logic [7:0] m_cnt;

  task automatic model_edge();
    int n, g;
    bit ok;
    logic [6:0] pn;
    if (!rst_n) begin
      hist.delete();
      m_comm = '0; m_any = 0; m_nib = '0;
      m_v = 0; m_b = 0; m_e = 0; m_u = 0; m_cnt = '0;
    end else begin
      hist.push_back(int'(seg));
      n   = hist.size();
      m_u = 0;
      if (n - S >= 2) begin
        ok = 1;
        for (int i = n - S - 2; i <= n - 3; i++)
          if (hist[i] != hist[n - S - 2]) ok = 0;
        pn = norm(7'(hist[n - S - 2]));
        if (ok && (!m_any || pn != m_comm)) begin
          g      = lookup(pn);
          m_any  = 1;
          m_comm = pn;
          m_v    = (g >= 0);
          m_b    = (pn == 7'h00);
          m_e    = !m_v && !m_b;
          if (m_v) m_nib = 4'(g);
          m_u    = 1;
          m_cnt  = m_cnt + 8'd1;
        end
      end
    end
  endtask

  int upd_seen;

  task automatic step(input logic [6:0] pins);
    seg = pins;
    @(posedge clk);
    model_edge();
    #1;
    chk("update", 32'(o_Update), 32'(m_u));
    chk("valid",  32'(o_Valid),  32'(m_v));
    chk("blank",  32'(o_Blank),  32'(m_b));
    chk("error",  32'(o_Error),  32'(m_e));
    chk("nibble", 32'(o_Nibble), 32'(m_nib));
    chk("count",  32'(o_Change_Count), 32'(m_cnt));
    upd_seen += int'(o_Update);
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {24'd0, o_Nibble, o_Valid, o_Blank, o_Error, o_Update},
        32'd0);
    chk(tag, 32'(o_Change_Count), 32'd0);
  endtask

  int first;
  int kind, hold;
  logic [6:0] pat;

  initial begin
    upd_seen = 0;
    rst_n = 1'b0;
    repeat (3) step(7'h7F);
    check_zero("reset");

    rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(~7'h5B);
      if (o_Update && first == 0) first = k;
    end
    chk("latency_edge", 32'(first), 32'd6);
    chk("first_nib", 32'(o_Nibble), 32'd2);
    chk("first_cnt", 32'(o_Change_Count), 32'd1);

    upd_seen = 0;
    repeat (2) step(~7'h06);
    repeat (8) step(~7'h5B);
    chk("glitch_noupd", 32'(upd_seen), 32'd0);
    chk("glitch_nib", 32'(o_Nibble), 32'd2);

    upd_seen = 0;
    for (int g = 0; g < 16; g++) begin
      repeat (10) step(~GL[g]);
      chk("sweep_nib", 32'(o_Nibble), 32'(g));
    end
    chk("sweep_pulses", 32'(upd_seen), 32'd16);

    repeat (10) step(~7'h50);
    chk("dash_err", 32'(o_Error), 32'd1);
    chk("dash_hold", 32'(o_Nibble), 32'hF);
    repeat (10) step(7'h7F);
    chk("blank", 32'(o_Blank), 32'd1);
    chk("blank_nv", 32'(o_Valid), 32'd0);

    rst_n = 1'b0;
    step(7'h7F);
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++)
      repeat (S + 3) step((k % 2) ? ~7'h06 : ~7'h3F);
    chk("wrap", 32'(o_Change_Count), 32'd0);

    repeat (3) step(~7'h66);
    rst_n = 1'b0;
    step(~7'h66);
    check_zero("mid_reset");
    rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(~7'h66);
      if (o_Update && first == 0) first = k;
    end
    chk("post_reset_edge", 32'(first), 32'(2 + S));

    for (int r = 0; r < 300; r++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6)      pat = ~GL[$urandom_range(0, 15)];
      else if (kind == 7) pat = 7'h7F;
      else if (kind == 8) pat = 7'($urandom);
      else                pat = ~7'h50;
      hold = $urandom_range(1, 7);
      repeat (hold) step(pat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
SEVEN_SEGMENT_DECODER -- requirements
Module: Seven_Segment_Decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples needed to commit a pattern; legal range 1..255.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 = pin low means segment lit; 0 = pin high means segment lit.
REQ-003 i_Clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_Reset_L  input  1  reset, synchronous, active-low.
REQ-005 i_Segments  input  7  raw segment pin levels, asynchronous; bit0=A, bit1=B ... bit6=G.
REQ-006 o_Nibble  output  4  value decoded from the last committed legal glyph.
REQ-007 o_Valid  output  1  committed pattern is a legal hex glyph.
REQ-008 o_Blank  output  1  committed pattern has all segments off.
REQ-009 o_Error  output  1  committed pattern is neither legal glyph nor blank.
REQ-010 o_Update  output  1  one-cycle pulse on every commit.
REQ-011 o_Change_Count  output  8  number of commits since reset.

Function
REQ-012 Inputs pass through a 2-flop synchronizer, then polarity normalization per ACTIVE_LOW, giving lit-high pattern P (bit6..bit0 = G..A).
REQ-013 Glyph table (P hex -> nibble):
- 3F->0, 06->1, 5B->2, 4F->3
- 66->4, 6D->5, 7D->6, 07->7
- 7F->8, 6F->9, 77->A, 7C->B
- 39->C, 5E->D, 79->E, 71->F
- Any other nonzero P, including 50 (E|G dash), is Error.
REQ-014 Stability counter: clear when P differs from P of the previous cycle; otherwise increment, saturating at STABLE_CYCLES.
REQ-015 Commit when the counter reaches STABLE_CYCLES and P differs from the committed pattern, or when the FSM is in S_WAIT.
REQ-016 Exactly one of o_Valid/o_Blank/o_Error is high after the first commit. All three are low in S_WAIT.
REQ-017 On commit:
- o_Valid, o_Blank and o_Error update per REQ-013.
- o_Nibble updates only when the new pattern is legal; otherwise it holds its prior value.
- o_Update pulses high for exactly one cycle.
- o_Change_Count increments, wrapping 255->0.
REQ-018 Latency: with an input held constant, commit outputs appear on the (2+STABLE_CYCLES)th rising edge after the first edge at which the new input is present.
REQ-019 A change held fewer than STABLE_CYCLES synchronized cycles produces no commit. Committed outputs and the count are unchanged.
REQ-020 A pattern that returns to the committed value after a glitch produces no commit.
REQ-021 FSM states:
- S_WAIT (no commit since reset).
- S_SETTLING (P differs from committed, counter below threshold).
- S_STABLE (P equals committed).
REQ-022 FSM transitions:
- S_WAIT -> S_STABLE on the first commit.
- S_STABLE -> S_SETTLING when P changes.
- S_SETTLING -> S_STABLE on commit or when P returns to committed.
- S_SETTLING -> S_SETTLING on any further change (counter cleared).

Reset
REQ-023 While i_Reset_L is low at a clock edge, the following are cleared to 0: o_Nibble, o_Valid, o_Blank, o_Error, o_Update, o_Change_Count, the synchronizer flops, the stability counter and the committed pattern; FSM = S_WAIT.
REQ-024 Reset asserted mid-settle discards the pending pattern. The first commit after reset requires a full STABLE_CYCLES window.

Structure
REQ-025 SEGMENT_A..SEGMENT_G bit masks and the 16 glyph codes live in the shared Seven_Segment_Display.vh header.
REQ-026 FSM state encodings live in a Seven_Segment_Decoder.vh header.
REQ-027 One combinational sub-module, Segment_Glyph_Lookup (7-bit P -> legal flag + 4-bit nibble), is instantiated once.

Verification
REQ-028 Reset, then hold pins ~7'h5B (ACTIVE_LOW=1, STABLE_CYCLES=4) -> o_Update on edge 6 and no earlier; o_Nibble=2, o_Valid=1, o_Change_Count=1.
REQ-029 From committed 2, drive ~7'h06 for 2 cycles then back to ~7'h5B -> no o_Update; all outputs unchanged.
REQ-030 Sweep all 16 glyph codes, each held 10 cycles -> o_Nibble 0..F in order; 16 single-cycle o_Update pulses.
REQ-031 Drive ~7'h50, then all pins high -> o_Error=1 with o_Nibble held; then o_Blank=1, o_Valid=0.
REQ-032 Commit 256 alternating patterns -> o_Change_Count wraps to 0. Assert i_Reset_L low mid-settle -> all outputs 0, FSM S_WAIT.
